// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder step per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed Overflow output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             busy_q, done_q;
  logic             s_bit, c_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign s_bit  = ra_q[0] ^ rb_q[0] ^ c_q;
  assign c_next = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);

  // ra doubles as the partial-sum register: sum bits enter at the MSB as operand bits leave
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          ra_d    = A;
          rb_d    = B;
          c_d     = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        ra_d  = {s_bit, ra_q[WIDTH-1:1]};
        rb_d  = {1'b0, rb_q[WIDTH-1:1]};
        c_d   = c_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = ra_d;
          carry_d = c_next;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = c_q ^ c_next;
`endif
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= {WIDTH{1'b0}};
      rb_q    <= {WIDTH{1'b0}};
      c_q     <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed stimulus for serial_adder (WIDTH=8) against a
// cycle-level reference built from A+B arithmetic and an accept/complete schedule.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic         Overflow;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Carry (Carry)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .Overflow (Overflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: an op is accepted when Start is seen while nothing is pending; its
  // result appears WIDTH edges later and the unit is free again one edge after that.
  int         cyc = 0;
  int         done_edge = 0;
  bit         pend = 1'b0;
  logic [W:0] p_full = '0;
  bit         p_ovf = 1'b0;
  logic [W-1:0] e_sum = '0;
  bit         e_carry = 1'b0;
  bit         e_ovf = 1'b0;
  bit         mon_en = 1'b0;

  function automatic bit signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] s;
    s = a + b;
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= 1'b0;
      e_sum   <= '0;
      e_carry <= 1'b0;
      e_ovf   <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!pend && Start) begin
        pend      <= 1'b1;
        done_edge <= cyc + 1 + W;
        p_full    <= {1'b0, A} + {1'b0, B};
        p_ovf     <= signed_ovf(A, B);
      end else if (pend && (cyc + 1 == done_edge)) begin
        e_sum   <= p_full[W-1:0];
        e_carry <= p_full[W];
        e_ovf   <= p_ovf;
      end else if (pend && (cyc + 1 == done_edge + 1)) begin
        pend <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("busy",  32'(Busy),  32'(pend));
      check("done",  32'(Done),  32'(pend && (cyc == done_edge)));
      check("sum",   32'(Sum),   32'(e_sum));
      check("carry", 32'(Carry), 32'(e_carry));
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf",   32'(Overflow), 32'(e_ovf));
`endif
    end
  end

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    lat = -1;
    @(negedge clk);
    Start = 1'b1; A = a; B = b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        Start = 1'b0; A = W'($urandom); B = W'($urandom);
      end
      if (Done) begin
        lat = i - 1;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(W));
  endtask

  initial begin
    int d1, d2, nd;
    rst = 1'b1; Start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(Busy),  32'(0));
    check("rst_done",  32'(Done),  32'(0));
    check("rst_sum",   32'(Sum),   32'(0));
    check("rst_carry", 32'(Carry), 32'(0));
    #2 rst = 1'b0;
    mon_en = 1'b1;

    run_op("t3c05", 8'h3C, 8'h05);
    check("t3c05_sum", 32'(Sum), 32'h41);
    check("t3c05_carry", 32'(Carry), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("t3c05_ovf", 32'(Overflow), 32'(0));
`endif
    run_op("tff01", 8'hFF, 8'h01);
    check("tff01_sum", 32'(Sum), 32'h00);
    check("tff01_carry", 32'(Carry), 32'(1));
    run_op("t7f01", 8'h7F, 8'h01);
    check("t7f01_sum", 32'(Sum), 32'h80);
    check("t7f01_carry", 32'(Carry), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("t7f01_ovf", 32'(Overflow), 32'(1));
`endif

    // Start held for 12 cycles: second op begins at the first IDLE cycle
    d1 = -1; d2 = -1; nd = 0;
    @(negedge clk);
    Start = 1'b1; A = 8'h10; B = 8'h20;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 12) Start = 1'b0;
      if (Done) begin
        nd++;
        check("hold_sum", 32'(Sum), 32'h30);
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    check("hold_ndone", 32'(nd), 32'(2));
    check("hold_first", 32'(d1), 32'(W + 1));
    check("hold_gap", 32'(d2 - d1), 32'(W + 2));

    // Start pulse with new operands mid-run must be ignored
    nd = 0;
    @(negedge clk);
    Start = 1'b1; A = 8'hAA; B = 8'h55;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 1) Start = 1'b0;
      if (i == 3) begin Start = 1'b1; A = 8'h01; B = 8'h01; end
      if (i == 4) Start = 1'b0;
      if (Done) begin
        nd++;
        check("ign_sum", 32'(Sum), 32'hFF);
        check("ign_carry", 32'(Carry), 32'(0));
      end
    end
    check("ign_ndone", 32'(nd), 32'(1));

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    Start = 1'b1; A = 8'h80; B = 8'h80;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) Start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  32'(Busy),  32'(0));
    check("arst_done",  32'(Done),  32'(0));
    check("arst_sum",   32'(Sum),   32'(0));
    check("arst_carry", 32'(Carry), 32'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    nd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (Done) nd++;
    end
    check("arst_nodone", 32'(nd), 32'(0));
    run_op("t8080", 8'h80, 8'h80);
    check("t8080_sum", 32'(Sum), 32'h00);
    check("t8080_carry", 32'(Carry), 32'(1));
`ifdef SERIAL_ADDER_OVF_EN
    check("t8080_ovf", 32'(Overflow), 32'(1));
`endif

    // Random operands and random Start timing, checked every cycle by the reference
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      Start = ($urandom_range(0, 2) == 0);
      A = W'($urandom);
      B = W'($urandom);
    end
    Start = 1'b0;
    repeat (W + 4) @(negedge clk);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
